rect_filler: RTL and testbench

Parametrised successor to the full-frame filler: fills an arbitrary axis-aligned rectangle of the frame buffer with a solid 24-bit colour by issuing 2-word DDR2 write bursts (8 pixels per burst) into the memory-controller address and write-data FIFOs. It clips the rectangle to the frame and byte-masks partial bursts at the left and right edges. It sits between the graphics command processor (valid/ready) and the DDR2 FIFO arbiter, in parallel with the line engine.

---
 rtl/rect_fill_pkg.sv | 7 +
 rtl/rect_mask_gen.sv | 18 +
 rtl/rect_filler.sv | 116 +++++++++++
 tb/tb_rect_filler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: shared states and constants for the rectangle filler
package rect_fill_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA2, FINISH} state_e;
  localparam int BURST_PIX = 8;
  localparam int PIX_PER_WORD = 4;
  localparam logic [15:0] MASK_ALL = 16'hFFFF;
endpackage

// File: rtl/rect_mask_gen.sv
// rect_mask_gen: byte mask for one 4-pixel word of a burst (1 = byte skipped)
module rect_mask_gen
  import rect_fill_pkg::*;
#(
  parameter int X_W = 10
) (
  input  logic [X_W-1:0] bx_i,
  input  logic           word_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [X_W-1:0] cx1_i,
  output logic [15:0]    mask_o
);
  for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_pix
    logic [X_W-1:0] p;
    assign p = bx_i + X_W'({word_i, 2'(k)});
    assign mask_o[4*k+3:4*k] = (p < x0_i || p > cx1_i) ? 4'hF : 4'h0;
  end
endmodule

// File: rtl/rect_filler.sv
// rect_filler: fills a clipped rectangle with a solid colour via 2-word DDR2 bursts
module rect_filler
  import rect_fill_pkg::*;
#(
  parameter int FRAME_W = 800,
  parameter int FRAME_H = 600,
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int ADDR_W = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [23:0]       color,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y1,
  input  logic [31:0]       frame_base,
  input  logic              af_full,
  input  logic              wdf_full,
  output logic [ADDR_W-1:0] af_addr_din,
  output logic              af_wr_en,
  output logic [127:0]      wdf_din,
  output logic [15:0]       wdf_mask_din,
  output logic              wdf_wr_en,
  output logic              ready,
  output logic              done
);
  state_e state_q, state_d;
  logic [23:0] color_q, color_d;
  logic [5:0] fsel_q, fsel_d;
  logic [X_W-1:0] x0_q, x0_d, cx1_q, cx1_d, bx_q, bx_d;
  logic [Y_W-1:0] y_q, y_d, cy1_q, cy1_d;
  logic [X_W-1:0] cx1_in;
  logic [Y_W-1:0] cy1_in;
  logic [15:0] mask_w;
  logic go, wrap, unused_fb;
  assign unused_fb = ^{frame_base[31:28], frame_base[21:0]};
  assign cx1_in = (x1 > X_W'(FRAME_W - 1)) ? X_W'(FRAME_W - 1) : x1;
  assign cy1_in = (y1 > Y_W'(FRAME_H - 1)) ? Y_W'(FRAME_H - 1) : y1;
  assign go = !af_full && !wdf_full;
  // Row ends once the next burst would start past the clipped right edge
  assign wrap = ({1'b0, bx_q} + (X_W+1)'(BURST_PIX)) > {1'b0, cx1_q};
  rect_mask_gen #(.X_W(X_W)) u_mask (
    .bx_i  (bx_q),
    .word_i(state_q == DATA2),
    .x0_i  (x0_q),
    .cx1_i (cx1_q),
    .mask_o(mask_w)
  );
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    fsel_d = fsel_q;
    x0_d = x0_q;
    cx1_d = cx1_q;
    cy1_d = cy1_q;
    bx_d = bx_q;
    y_d = y_q;
    af_wr_en = 1'b0;
    wdf_wr_en = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        color_d = color;
        fsel_d = frame_base[27:22];
        x0_d = x0;
        cx1_d = cx1_in;
        cy1_d = cy1_in;
        bx_d = {x0[X_W-1:3], 3'b0};
        y_d = y0;
        state_d = (x0 > cx1_in || y0 > cy1_in) ? FINISH : CMD;
      end
      CMD: begin
        af_wr_en = go;
        wdf_wr_en = go;
        state_d = go ? DATA2 : CMD;
      end
      DATA2: begin
        wdf_wr_en = !wdf_full;
        if (!wdf_full) begin
          bx_d = wrap ? {x0_q[X_W-1:3], 3'b0} : bx_q + X_W'(BURST_PIX);
          y_d = wrap ? y_q + Y_W'(1) : y_q;
          state_d = (wrap && y_q == cy1_q) ? FINISH : CMD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= '0;
      fsel_q <= '0;
      x0_q <= '0;
      cx1_q <= '0;
      cy1_q <= '0;
      bx_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      fsel_q <= fsel_d;
      x0_q <= x0_d;
      cx1_q <= cx1_d;
      cy1_q <= cy1_d;
      bx_q <= bx_d;
      y_q <= y_d;
    end
  end
  assign ready = state_q == IDLE;
  assign done = state_q == FINISH;
  assign wdf_din = {4{8'h00, color_q}};
  assign wdf_mask_din = (state_q == CMD || state_q == DATA2) ? mask_w : MASK_ALL;
  assign af_addr_din = ADDR_W'({fsel_q, y_q, bx_q[X_W-1:3], 2'b00});
endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: directed checks of rect_filler on an 800x60 frame
module tb_rect_filler;
  localparam int FW = 800;
  localparam int FH = 60;
  logic clk = 0, rst = 1, valid = 0, af_full = 0, wdf_full = 0;
  logic [23:0] color = 0;
  logic [9:0] x0 = 0, x1 = 0, y0 = 0, y1 = 0;
  logic [31:0] frame_base = 0;
  logic [30:0] af_addr_din;
  logic [127:0] wdf_din;
  logic [15:0] wdf_mask_din;
  logic af_wr_en, wdf_wr_en, ready, done;
  rect_filler #(.FRAME_W(FW), .FRAME_H(FH), .X_W(10), .Y_W(10), .ADDR_W(31)) dut (
    .clk(clk), .rst(rst), .valid(valid), .color(color), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .frame_base(frame_base), .af_full(af_full), .wdf_full(wdf_full), .af_addr_din(af_addr_din),
    .af_wr_en(af_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .ready(ready), .done(done)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_miss = 0;
  int af_cnt = 0, wdf_cnt = 0, done_cnt = 0, nz_mask = 0, viol = 0;
  int a0, w0, d0, n0, v0;
  logic [30:0] last_addr = 0;
  logic [30:0] aq[$];
  logic [15:0] mq[$];
  always @(negedge clk) if (!rst) begin
    if (af_wr_en) begin
      af_cnt++;
      last_addr = af_addr_din;
      aq.push_back(af_addr_din);
    end
    if (wdf_wr_en) begin
      wdf_cnt++;
      if (wdf_mask_din != 16'h0) nz_mask++;
      mq.push_back(wdf_mask_din);
    end
    if (done) done_cnt++;
    if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full)) viol++;
  end
  function automatic logic [30:0] addr(int f, int y, int bx);
    return 31'((f << 19) | (y << 9) | ((bx >> 3) << 2));
  endfunction
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mark;
    a0 = af_cnt; w0 = wdf_cnt; d0 = done_cnt; n0 = nz_mask; v0 = viol;
    aq.delete();
    mq.delete();
  endtask
  task automatic issue(int ax0, int ax1, int ay0, int ay1, int f);
    x0 = 10'(ax0); x1 = 10'(ax1); y0 = 10'(ay0); y1 = 10'(ay1);
    frame_base = 32'(f) << 22;
    valid = 1;
    tick;
    valid = 0;
  endtask
  task automatic wait_done(int budget);
    int d;
    d = done_cnt;
    for (int i = 0; i < budget && done_cnt == d; i++) tick;
    chk("done_seen", 128'(done_cnt - d), 1);
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_af_en", af_wr_en, 0);
    chk("rst_wdf_en", wdf_wr_en, 0);
    chk("rst_mask", wdf_mask_din, 16'hFFFF);
    chk("rst_addr", af_addr_din, 0);
    rst = 0;
    tick;
    // small rectangle with partial bursts at both edges
    mark;
    color = 24'hABCDEF;
    issue(3, 10, 5, 5, 2);
    chk("rect_ready_low", ready, 0);
    chk("rect_af_first", af_wr_en, 1);
    chk("rect_addr0", af_addr_din, addr(2, 5, 0));
    chk("rect_din", wdf_din, {4{32'h00ABCDEF}});
    wait_done(50);
    chk("rect_ready_back", ready, 1);
    chk("rect_af_cnt", 128'(af_cnt - a0), 2);
    chk("rect_wdf_cnt", 128'(wdf_cnt - w0), 4);
    chk("rect_addr1", aq[1], addr(2, 5, 8));
    chk("rect_mask0", mq[0], 16'h0FFF);
    chk("rect_mask1", mq[1], 16'h0000);
    chk("rect_mask2", mq[2], 16'hF000);
    chk("rect_mask3", mq[3], 16'hFFFF);
    // empty command
    mark;
    issue(20, 10, 0, 0, 0);
    chk("empty_done", done, 1);
    chk("empty_ready_low", ready, 0);
    tick;
    chk("empty_ready", ready, 1);
    chk("empty_done_off", done, 0);
    chk("empty_writes", 128'(af_cnt - a0 + wdf_cnt - w0), 0);
    // clipping at the bottom-right corner
    mark;
    issue(792, 1000, 58, 700, 1);
    wait_done(50);
    chk("clip_af_cnt", 128'(af_cnt - a0), 2);
    chk("clip_wdf_cnt", 128'(wdf_cnt - w0), 4);
    chk("clip_addr0", aq[0], addr(1, 58, 792));
    chk("clip_addr1", aq[1], addr(1, 59, 792));
    chk("clip_masks", 128'(nz_mask - n0), 0);
    // backpressure on both FIFOs, with a stray valid while busy
    mark;
    af_full = 1;
    issue(2, 13, 3, 3, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_af_hold", af_wr_en, 0);
      chk("bp_wdf_hold", wdf_wr_en, 0);
      chk("bp_cmd_mask", wdf_mask_din, 16'h00FF);
      chk("bp_cmd_addr", af_addr_din, addr(3, 3, 0));
      valid = (i == 2);
      x0 = 10'd400;
      tick;
    end
    valid = 0;
    af_full = 0;
    #1;
    chk("bp_go", af_wr_en, 1);
    tick;
    wdf_full = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data_hold", wdf_wr_en, 0);
      chk("bp_data_mask", wdf_mask_din, 16'h0000);
      chk("bp_data_addr", af_addr_din, addr(3, 3, 0));
      tick;
    end
    wdf_full = 0;
    wait_done(50);
    chk("bp_af_cnt", 128'(af_cnt - a0), 2);
    chk("bp_wdf_cnt", 128'(wdf_cnt - w0), 4);
    chk("bp_viol", 128'(viol - v0), 0);
    chk("bp_addr1", aq[1], addr(3, 3, 8));
    chk("bp_mask0", mq[0], 16'h00FF);
    chk("bp_mask1", mq[1], 16'h0000);
    chk("bp_mask2", mq[2], 16'h0000);
    chk("bp_mask3", mq[3], 16'hFF00);
    // full frame, y1 clipped to the last row
    mark;
    issue(0, 799, 0, 599, 0);
    wait_done(13000);
    chk("full_af_cnt", 128'(af_cnt - a0), 6000);
    chk("full_wdf_cnt", 128'(wdf_cnt - w0), 12000);
    chk("full_masks", 128'(nz_mask - n0), 0);
    chk("full_last_addr", last_addr, addr(0, 59, 792));
    chk("full_ready", ready, 1);
    // reset after the third burst of a full-frame fill
    mark;
    issue(0, 799, 0, 599, 0);
    for (int i = 0; i < 100 && af_cnt - a0 < 3; i++) tick;
    chk("mid_reach3", 128'(af_cnt - a0), 3);
    tick;
    rst = 1;
    tick;
    chk("mid_ready", ready, 1);
    chk("mid_af_en", af_wr_en, 0);
    chk("mid_wdf_en", wdf_wr_en, 0);
    chk("mid_mask", wdf_mask_din, 16'hFFFF);
    rst = 0;
    repeat (5) tick;
    chk("mid_af_cnt", 128'(af_cnt - a0), 3);
    chk("mid_wdf_cnt", 128'(wdf_cnt - w0), 6);
    chk("mid_no_done", 128'(done_cnt - d0), 0);
    mark;
    issue(16, 23, 7, 8, 5);
    wait_done(50);
    chk("post_af_cnt", 128'(af_cnt - a0), 2);
    chk("post_wdf_cnt", 128'(wdf_cnt - w0), 4);
    chk("post_addr0", aq[0], addr(5, 7, 16));
    chk("post_addr1", aq[1], addr(5, 8, 16));
    chk("post_masks", 128'(nz_mask - n0), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
